// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared definitions for the instruction-memory boot path:
//                boot controller state encoding and the canonical NOP word
//                (addi x0,x0,0) returned on any fetch that cannot be served.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  // Boot controller states, in the order they are normally visited.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } boot_state_t;

  // RV32I canonical NOP: addi x0, x0, 0
  localparam logic [31:0] C_NOP_WORD = 32'h0000_0013;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : imem_boot_ctrl
//  Description : Boot controller for an external single-port instruction
//                memory. After reset it zero-fills the whole memory, then
//                waits for a start pulse, streams load_count words into
//                addresses 0.. from a valid/ready stream, and finally hands
//                the memory port over to the core for instruction fetch.
//  Ports       : clk, reset          - clock, synchronous active-high reset
//                start, load_count   - load request and word count
//                s_valid/s_data/s_ready - load stream handshake
//                fetch_addr/fetch_instr/fetch_fault - core fetch port
//                mem_we/mem_addr/mem_wdata/mem_rdata - shared memory port
//                core_stall, done, err - status to the system
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_boot_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] NOP_WORD = C_NOP_WORD
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     load_count,
  input  logic                       s_valid,
  input  logic [31:0]                s_data,
  output logic                       s_ready,
  input  logic [31:0]                fetch_addr,
  output logic [31:0]                fetch_instr,
  output logic                       mem_we,
  output logic [$clog2(DEPTH)-1:0]   mem_addr,
  output logic [31:0]                mem_wdata,
  input  logic [31:0]                mem_rdata,
  output logic                       core_stall,
  output logic                       done,
  output logic                       err,
  output logic                       fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] C_CLEAR_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_DEPTH      = CW'(DEPTH);

  boot_state_t   r_state, w_state_nxt;
  logic [CW-1:0] r_cnt,   w_cnt_nxt;
  logic [CW-1:0] r_len,   w_len_nxt;
  logic          r_err,   w_err_nxt;
  logic          r_done,  w_done_nxt;

  logic          w_start_ok;
  logic          w_fetch_ok;

  // A legal load is 1..DEPTH words.
  assign w_start_ok = (load_count != '0) && (load_count <= C_DEPTH);

  // DEPTH is a power of two, so "word index >= DEPTH" is simply any set bit
  // above the word-address field.
  assign w_fetch_ok = (fetch_addr[1:0] == 2'b00) && (fetch_addr[31:AW+2] == '0);

  // Status outputs are forced to their reset values while reset is held,
  // not only after the reset edge.
  assign core_stall = reset | (r_state != ST_RUN);
  assign done       = r_done & ~reset;
  assign err        = r_err  & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_err   <= w_err_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    w_err_nxt   = r_err;
    w_done_nxt  = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    s_ready     = 1'b0;
    fetch_instr = NOP_WORD;
    fetch_fault = 1'b0;

    case (r_state)
      ST_CLEAR: begin
        mem_we   = 1'b1;
        mem_addr = r_cnt[AW-1:0];
        if (r_cnt == C_CLEAR_LAST) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      ST_LOAD: begin
        s_ready   = 1'b1;
        mem_addr  = r_cnt[AW-1:0];
        mem_wdata = s_data;
        mem_we    = s_valid;
        if (s_valid) begin
          if (r_cnt == r_len - 1'b1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      ST_IDLE, ST_RUN: begin
        if (r_state == ST_RUN) begin
          mem_addr = fetch_addr[AW+1:2];
          if (w_fetch_ok) begin
            fetch_instr = mem_rdata;
          end else begin
            fetch_fault = 1'b1;
          end
        end
        // A reload from RUN goes straight to LOAD; the memory is not cleared
        // again, so words past the new load_count keep their old contents.
        if (start) begin
          if (w_start_ok) begin
            w_len_nxt   = load_count;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_LOAD;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end

      default: begin
        w_state_nxt = ST_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase

    if (reset) begin
      mem_we  = 1'b0;
      s_ready = 1'b0;
    end
  end

endmodule : imem_boot_ctrl
`default_nettype wire

// File: tb/tb_imem_boot_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_boot_ctrl
//  Description : Scoreboard bench for imem_boot_ctrl. Stimulus pushes the
//                expected memory writes and done pulses into queues; a monitor
//                pops and compares whenever the DUT writes or pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_boot_ctrl;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        start;
  logic [6:0]  load_count;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        core_stall;
  logic        done;
  logic        err;
  logic        fetch_fault;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_wr[$];
  int          pending_done;
  int          checks;
  int          errors;
  logic [31:0] mem [DEPTH];
  logic [31:0] prog [9];

  imem_boot_ctrl #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .load_count (load_count),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .fetch_addr (fetch_addr),
    .fetch_instr(fetch_instr),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .core_stall (core_stall),
    .done       (done),
    .err        (err),
    .fetch_fault(fetch_fault)
  );

  assign mem_rdata = mem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = 6'(a);
    e.data = d;
    exp_wr.push_back(e);
  endtask

  task automatic push_clear();
    for (int i = 0; i < DEPTH; i++) push_wr(i, 32'h0);
  endtask

  task automatic do_start(input int n);
    start      = 1'b1;
    load_count = 7'(n);
    @(posedge clk); #1;
    start      = 1'b0;
  endtask

  task automatic send(input logic v, input logic [31:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while ((exp_wr.size() != 0 || pending_done != 0) && n < max) begin
      @(posedge clk);
      n++;
    end
    if (exp_wr.size() != 0 || pending_done != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d writes and %0d done pulses outstanding, required 0",
               exp_wr.size(), pending_done);
      exp_wr.delete();
      pending_done = 0;
    end
    #1;
  endtask

  task automatic chk_fetch(input logic [31:0] a, input logic [31:0] instr, input logic fault);
    fetch_addr = a;
    #1;
    chk($sformatf("fetch_instr@%h", a), fetch_instr, instr);
    chk($sformatf("fetch_fault@%h", a), {31'b0, fetch_fault}, {31'b0, fault});
  endtask

  initial begin
    wr_t e;
    checks       = 0;
    errors       = 0;
    pending_done = 0;
    reset        = 1'b1;
    start        = 1'b0;
    load_count   = '0;
    s_valid      = 1'b0;
    s_data       = '0;
    fetch_addr   = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
    prog[0] = 32'h0000_0013; prog[1] = 32'h0050_0293; prog[2] = 32'h0060_0313;
    prog[3] = 32'h0062_83b3; prog[4] = 32'h0070_2023; prog[5] = 32'h0000_2403;
    prog[6] = 32'h0014_0413; prog[7] = 32'h0080_2223; prog[8] = 32'h0000_0073;

    fork
      forever begin
        @(posedge clk);
        if (mem_we) mem[mem_addr] <= mem_wdata;
      end
      forever begin
        @(negedge clk);
        if (mem_we) begin
          if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                     mem_addr, mem_wdata);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", {26'b0, mem_addr}, {26'b0, e.addr});
            chk("wr_data", mem_wdata, e.data);
          end
        end
        if (done) begin
          if (pending_done == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1, required 0");
          end else begin
            pending_done--;
            chk("done_core_stall", {31'b0, core_stall}, 32'd0);
            chk("done_s_ready", {31'b0, s_ready}, 32'd0);
          end
        end
      end
    join_none

    // Reset: status outputs held at their reset values.
    push_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_core_stall", {31'b0, core_stall}, 32'd1);
    chk("rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    reset = 1'b0;

    // Clear: 64 zero writes at 0..63, stalled throughout.
    repeat (10) @(posedge clk);
    #1;
    chk("clear_core_stall", {31'b0, core_stall}, 32'd1);
    chk("clear_fetch_nop", fetch_instr, NOP);
    wait_drain(80);
    chk("idle_core_stall", {31'b0, core_stall}, 32'd1);
    chk("idle_s_ready", {31'b0, s_ready}, 32'd0);

    // Illegal load counts from IDLE: err set, no writes, still IDLE.
    do_start(0);
    chk("err_cnt0", {31'b0, err}, 32'd1);
    do_start(65);
    repeat (2) @(posedge clk);
    #1;
    chk("err_cnt65", {31'b0, err}, 32'd1);
    chk("err_stay_idle_stall", {31'b0, core_stall}, 32'd1);
    chk("err_stay_idle_ready", {31'b0, s_ready}, 32'd0);

    // Nine back-to-back words.
    for (int i = 0; i < 9; i++) push_wr(i, prog[i]);
    pending_done = 1;
    do_start(9);
    chk("load_s_ready", {31'b0, s_ready}, 32'd1);
    for (int i = 0; i < 9; i++) send(1'b1, prog[i]);
    chk("load9_done_cycle", {31'b0, done}, 32'd1);
    wait_drain(20);
    chk("run_core_stall", {31'b0, core_stall}, 32'd0);
    chk("err_sticky_after_load", {31'b0, err}, 32'd1);

    // Fetch in RUN.
    chk_fetch(32'h0000_0004, 32'h0050_0293, 1'b0);
    chk_fetch(32'h0000_0000, 32'h0000_0013, 1'b0);
    chk_fetch(32'h0000_0020, 32'h0000_0073, 1'b0);
    chk_fetch(32'h0000_0024, 32'h0000_0000, 1'b0);
    chk_fetch(32'h0000_00FC, 32'h0000_0000, 1'b0);
    chk_fetch(32'h0000_0006, NOP, 1'b1);
    chk_fetch(32'h0000_0100, NOP, 1'b1);
    fetch_addr = '0;
    @(posedge clk); #1;

    // Reload of 3 words with stream gaps; words 3.. keep old contents.
    push_wr(0, 32'h0010_0093);
    push_wr(1, 32'h0020_0113);
    push_wr(2, 32'h0030_8193);
    pending_done = 1;
    do_start(3);
    send(1'b1, 32'h0010_0093);
    send(1'b0, 32'hBAD0_0001);
    send(1'b0, 32'hBAD0_0002);
    send(1'b1, 32'h0020_0113);
    send(1'b0, 32'hBAD0_0003);
    send(1'b1, 32'h0030_8193);
    wait_drain(20);
    chk_fetch(32'h0000_0000, 32'h0010_0093, 1'b0);
    chk_fetch(32'h0000_0008, 32'h0030_8193, 1'b0);
    chk_fetch(32'h0000_000C, 32'h0062_83b3, 1'b0);
    fetch_addr = '0;
    @(posedge clk); #1;

    // Reset after 4 of 9 words: load abandoned, clear restarts at 0, no done.
    for (int i = 0; i < 4; i++) push_wr(i, prog[i]);
    do_start(9);
    for (int i = 0; i < 4; i++) send(1'b1, prog[i]);
    push_clear();
    reset   = 1'b1;
    s_valid = 1'b1;
    s_data  = prog[4];
    #1;
    chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("midrst_core_stall", {31'b0, core_stall}, 32'd1);
    chk("midrst_err", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    reset   = 1'b0;
    s_valid = 1'b0;
    wait_drain(80);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_core_stall", {31'b0, core_stall}, 32'd1);
    chk("post_rst_err", {31'b0, err}, 32'd0);
    chk("post_rst_s_ready", {31'b0, s_ready}, 32'd0);
    chk("queues_empty", 32'(exp_wr.size() + pending_done), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_imem_boot_ctrl
`default_nettype wire

// File: doc/imem_boot_ctrl.md
IMEM_BOOT_CTRL -- requirements
Module: imem_boot_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter NOP_WORD, default 32'h00000013, meaning the word returned on any invalid fetch.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle pulse that begins a program load.
REQ-006 SHALL have port load_count  input  $clog2(DEPTH)+1  number of words to load; sampled on start.
REQ-007 SHALL have port s_valid  input  1  load-stream word valid.
REQ-008 SHALL have port s_data  input  32  load-stream instruction word.
REQ-009 SHALL have port s_ready  output  1  load stream accepts a word this cycle.
REQ-010 SHALL have port fetch_addr  input  32  core PC, byte address.
REQ-011 SHALL have port fetch_instr  output  32  instruction returned to the core, combinational.
REQ-012 SHALL have port mem_we  output  1  memory write enable.
REQ-013 SHALL have port mem_addr  output  $clog2(DEPTH)  shared single-port word address.
REQ-014 SHALL have port mem_wdata  output  32  memory write data.
REQ-015 SHALL have port mem_rdata  input  32  memory asynchronous read data at mem_addr.
REQ-016 SHALL have port core_stall  output  1  high whenever state is not RUN.
REQ-017 SHALL have port done  output  1  one-cycle pulse when a load completes.
REQ-018 SHALL have port err  output  1  sticky: illegal load_count on start.
REQ-019 SHALL have port fetch_fault  output  1  combinational: misaligned or out-of-range fetch in RUN.

Function
REQ-020 SHALL implement FSM states CLEAR, IDLE, LOAD, RUN.
REQ-021 CLEAR SHALL write 0 to addresses 0..DEPTH-1, one word per cycle (mem_we=1), for exactly DEPTH cycles, then go to IDLE.
REQ-022 IDLE: start with 1<=load_count<=DEPTH SHALL latch load_count, clear word counter, go to LOAD; otherwise start SHALL set err and stay IDLE.
REQ-023 LOAD: s_ready SHALL be 1; each cycle with s_valid=1 SHALL write s_data to mem_addr=counter and increment counter; s_valid=0 cycles SHALL write nothing.
REQ-024 Acceptance of word index load_count-1 SHALL move to RUN next cycle and pulse done in that same next cycle; s_ready SHALL be 0 from that cycle on.
REQ-025 RUN: mem_we=0, mem_addr=fetch_addr[$clog2(DEPTH)+1:2], fetch_instr=mem_rdata when fetch is valid.
REQ-026 Fetch SHALL be invalid when fetch_addr[1:0]!=0 or fetch_addr>>2 >= DEPTH; then fetch_instr=NOP_WORD and fetch_fault=1.
REQ-027 Outside RUN, fetch_instr SHALL be NOP_WORD and fetch_fault 0.
REQ-028 start in RUN SHALL behave as in IDLE (reload path, or err); memory is not re-cleared; start in CLEAR or LOAD SHALL be ignored.
REQ-029 Words beyond load_count SHALL retain prior contents (zero after CLEAR).
REQ-030 err SHALL clear only on reset.

Reset
REQ-031 reset SHALL force state CLEAR, counter 0, err 0, done 0, core_stall 1, s_ready 0, mem_we 0 in the reset cycle; reset mid-LOAD or mid-RUN SHALL abandon the load and restart CLEAR.

Structure
REQ-032 State encoding and NOP_WORD SHALL reside in shared package riscv_pkg.
REQ-033 Block SHALL be a single module with no sub-modules; the memory array is external (Instruction_Mem-compatible storage wrapped with a write port).

Verification
REQ-034 Reset then 64 idle cycles -> mem_we=1 for exactly 64 cycles, addresses 0..63, data 0; core_stall=1 throughout, IDLE after.
REQ-035 start, load_count=9, nine back-to-back words 0x00000013,0x00500293,...,0x00000073 -> writes addr 0..8, done one cycle after 9th accept, core_stall falls with done.
REQ-036 load_count=3 with s_valid gaps (1,0,0,1,0,1) -> exactly 3 writes, counter holds during gaps.
REQ-037 start with load_count=0 and =65 -> err=1, stays IDLE, no writes; err stays set after a later legal load.
REQ-038 RUN, fetch_addr=0x4 -> fetch_instr=0x00500293; 0x6 and 0x100 -> NOP_WORD, fetch_fault=1.
REQ-039 reset asserted after 4 of 9 words -> CLEAR restarts at addr 0, done never pulses.
